count_event_monitor: RTL and testbench
======================================

# count_event_monitor

Downstream consumer of the 8-bit up counter's `Count` output. It watches the count stream, detects arrival at a programmable compare value and the 255→0 wrap, and reports each detected event to a control consumer over a valid/ack handshake. It also keeps a saturating tally of matches and a sticky overflow flag for events dropped while one is still unacknowledged.

## Interface
Parameters:
- `WIDTH`, 8: width of the count and compare values.
- `TALLYW`, 4: width of the match tally.

Ports:
- `Clock`, in, 1: rising-edge clock, shared with the counter.
- `Reset`, in, 1: synchronous, active-high reset.
- `CountIn`, in, WIDTH: counter output, sampled every rising edge.
- `CmpLoad`, in, 1: load `CmpData` into the compare register.
- `CmpData`, in, WIDTH: compare value.
- `Arm`, in, 1: level; enables event detection.
- `EventAck`, in, 1: consumer acknowledges the pending event.
- `Match`, out, 1: one-cycle pulse on match detect.
- `Wrap`, out, 1: one-cycle pulse on wrap detect.
- `EventValid`, out, 1: an event is pending.
- `EventCode`, out, 2: {wrap, match} of the pending event.
- `MatchTally`, out, TALLYW: saturating match count.
- `Overflow`, out, 1: sticky; an event was lost.
- `State`, out, 2: FSM state, for debug.

## Operation
- Registers and reset values (all synchronous, applied when `Reset`=1):
  - compare register = 0.
  - `prev_count` = 0.
  - `prev_valid` = 0.
  - `State` = IDLE (2'b00).
  - All outputs = 0.
- `Reset` has priority over every other input in the same cycle.
- Every non-reset edge loads `prev_count`←`CountIn` and sets `prev_valid`=1.
- A sample is *new* when `prev_valid`=0 or `CountIn`≠`prev_count`. A held count (counter disabled) therefore never re-triggers a match.
- Match detect: state≠IDLE, sample is new, and `CountIn`==compare register.
- Wrap detect: state≠IDLE, `prev_valid`=1, `prev_count`==2^WIDTH−1, and `CountIn`==0.
  - A parallel load of 0 taken from 255 counts as a wrap.
  - A counter reset from any other value does not.
- Match and wrap can be detected together; the code is then 2'b11.
- `CmpLoad`: the new value is used from the next edge. A compare in the same cycle uses the old value.
- `MatchTally` increments on each `Match` pulse and saturates at 2^TALLYW−1. It is cleared only by `Reset`.
- FSM states: IDLE=00, ARMED=01, PENDING=10.
  - IDLE: `Arm`=1 → ARMED. No detection while in IDLE.
  - ARMED: `Arm`=0 → IDLE. An event detected (with `Arm`=1) → PENDING, and `EventCode` captures {wrap, match}.
  - PENDING: `EventValid`=1 and `EventCode` holds stable until acknowledged.
    - `EventAck`=1 with no new event → ARMED if `Arm`=1, else IDLE.
    - `EventAck`=1 with a new event → stay PENDING and capture the new code (back-to-back handshake, no bubble).
    - New event with `EventAck`=0 → `Overflow`←1 and the code is unchanged.
    - `Arm`=0 does not drop a pending event; the event completes its handshake first.
- `EventAck` is ignored when `EventValid`=0.
- `Overflow` is cleared only by `Reset`.

## Timing
- Latency: a detect on the sample taken at edge N drives `Match`/`Wrap` high for exactly the cycle after edge N. `EventValid` rises on the same edge.
- Handshake completes on the edge where `EventValid`=1 and `EventAck`=1. `EventValid` falls on that edge unless a back-to-back event is captured.
- `Arm` rising at edge N: detection is active for the sample at edge N+1.
- `Reset` mid-PENDING: the event is discarded. The first sample after reset is new but cannot produce a wrap.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset, then `CmpLoad`=1 with `CmpData`=5, then `Arm`=1 with the counter counting 0..8 → one `Match` pulse the cycle after `CountIn`=5, `EventCode`=01, `MatchTally`=1.
- Counter held at 5 for 4 cycles, with the event already acknowledged → no second `Match`, tally stays 1.
- Counter loaded with 250 and counting through 255→0, compare register = 0 → `Wrap` and `Match` pulse together, `EventCode`=11.
- Event pending with no ack, then a second match (compare = 3 and the counter wraps to 3) → `Overflow`=1, `EventCode` unchanged. Ack in the same cycle as the next event → `EventValid` stays 1 and the new code is captured.
- `Arm`=0 while PENDING → `EventValid` held until ack, then `State`=IDLE. Counting through the compare value in IDLE → no pulses.
- `Reset`=1 asserted during PENDING with `MatchTally`=15 (saturated after 20 matches) → next cycle all outputs are 0 and `State`=IDLE.

Source files
------------

// File: rtl/count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_event_monitor
// Description : Watches a counter stream for compare matches and 255->0 wraps
//               and reports each event over a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_monitor #(
    parameter int WIDTH  = 8,
    parameter int TALLYW = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  CountIn,
    input  logic              CmpLoad,
    input  logic [WIDTH-1:0]  CmpData,
    input  logic              Arm,
    input  logic              EventAck,
    output logic              Match,
    output logic              Wrap,
    output logic              EventValid,
    output logic [1:0]        EventCode,
    output logic [TALLYW-1:0] MatchTally,
    output logic              Overflow,
    output logic [1:0]        State
);

    localparam logic [1:0]        ST_IDLE    = 2'b00;
    localparam logic [1:0]        ST_ARMED   = 2'b01;
    localparam logic [1:0]        ST_PENDING = 2'b10;
    localparam logic [TALLYW-1:0] TALLY_MAX  = {TALLYW{1'b1}};
    localparam logic [WIDTH-1:0]  COUNT_MAX  = {WIDTH{1'b1}};

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] cmp_value;
    logic [WIDTH-1:0] prev_count;
    logic             prev_valid;

    logic sample_new;
    logic det_match;
    logic det_wrap;
    logic det_event;
    logic capture;
    logic drop;

    // A held count is not new, so a stopped counter cannot re-trigger a match.
    assign sample_new = !prev_valid || (CountIn != prev_count);
    assign det_match  = (state != ST_IDLE) && sample_new && (CountIn == cmp_value);
    assign det_wrap   = (state != ST_IDLE) && prev_valid
                        && (prev_count == COUNT_MAX) && (CountIn == '0);
    assign det_event  = det_match || det_wrap;
    assign capture    = det_event && (((state == ST_ARMED) && Arm)
                                   || ((state == ST_PENDING) && EventAck));
    assign drop       = det_event && (state == ST_PENDING) && !EventAck;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (Arm) next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (!Arm)          next_state = ST_IDLE;
                else if (det_event) next_state = ST_PENDING;
            end
            ST_PENDING: begin
                // A pending event always finishes its handshake, even if disarmed.
                if (EventAck && !det_event) next_state = Arm ? ST_ARMED : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        EventValid = (state == ST_PENDING);
        State      = state;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cmp_value  <= '0;
            prev_count <= '0;
            prev_valid <= 1'b0;
            Match      <= 1'b0;
            Wrap       <= 1'b0;
            EventCode  <= 2'b00;
            MatchTally <= '0;
            Overflow   <= 1'b0;
        end else begin
            prev_count <= CountIn;
            prev_valid <= 1'b1;
            if (CmpLoad) cmp_value <= CmpData;
            Match <= det_match;
            Wrap  <= det_wrap;
            if (capture) EventCode <= {det_wrap, det_match};
            if (det_match && (MatchTally != TALLY_MAX)) MatchTally <= MatchTally + 1'b1;
            if (drop) Overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_event_monitor
// Description : Directed scoreboard bench for count_event_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_event_monitor;

    typedef struct packed {
        logic       m;
        logic       w;
        logic       v;
        logic [1:0] code;
        logic [3:0] tally;
        logic       ovf;
    } exp_t;

    logic       Clock;
    logic       Reset;
    logic [7:0] CountIn;
    logic       CmpLoad;
    logic [7:0] CmpData;
    logic       Arm;
    logic       EventAck;
    logic       Match;
    logic       Wrap;
    logic       EventValid;
    logic [1:0] EventCode;
    logic [3:0] MatchTally;
    logic       Overflow;
    logic [1:0] State;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t mon_exp;
    exp_t mon_act;

    count_event_monitor #(.WIDTH(8), .TALLYW(4)) dut (
        .Clock(Clock), .Reset(Reset), .CountIn(CountIn), .CmpLoad(CmpLoad),
        .CmpData(CmpData), .Arm(Arm), .EventAck(EventAck), .Match(Match),
        .Wrap(Wrap), .EventValid(EventValid), .EventCode(EventCode),
        .MatchTally(MatchTally), .Overflow(Overflow), .State(State)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic cnt(input int v);
        CountIn = v[7:0];
        tick();
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_pulse(input logic m, input logic w, input logic [1:0] code,
                                input int tally, input logic ovf);
        exp_t e;
        e.m = m; e.w = w; e.v = 1'b1; e.code = code;
        e.tally = tally[3:0]; e.ovf = ovf;
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_match"},  int'(Match),      0);
        check({tag, "_wrap"},   int'(Wrap),       0);
        check({tag, "_valid"},  int'(EventValid), 0);
        check({tag, "_code"},   int'(EventCode),  0);
        check({tag, "_tally"},  int'(MatchTally), 0);
        check({tag, "_ovf"},    int'(Overflow),   0);
        check({tag, "_state"},  int'(State),      0);
    endtask

    // Monitor: every Match/Wrap pulse must correspond to the next queued expectation.
    always @(negedge Clock) begin
        if (Match || Wrap) begin
            tests++;
            mon_act = {Match, Wrap, EventValid, EventCode, MatchTally, Overflow};
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got match=%0b wrap=%0b, required no pulse",
                         Match, Wrap);
            end else begin
                mon_exp = q.pop_front();
                if (mon_act !== mon_exp) begin
                    fails++;
                    $display("FAIL event_record: got m=%0b w=%0b v=%0b code=%0b tally=%0d ovf=%0b, required m=%0b w=%0b v=%0b code=%0b tally=%0d ovf=%0b",
                             mon_act.m, mon_act.w, mon_act.v, mon_act.code, mon_act.tally, mon_act.ovf,
                             mon_exp.m, mon_exp.w, mon_exp.v, mon_exp.code, mon_exp.tally, mon_exp.ovf);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; CountIn = 8'd0; CmpLoad = 1'b0; CmpData = 8'd0;
        Arm = 1'b0; EventAck = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        Reset = 1'b0;

        // Compare = 5, arm, count up to 5
        CmpLoad = 1'b1; CmpData = 8'd5; cnt(0);
        CmpLoad = 1'b0;
        check("idle_no_arm_state", int'(State), 0);
        Arm = 1'b1; cnt(0);
        check("armed_state", int'(State), 1);
        for (int i = 1; i <= 4; i++) cnt(i);
        expect_pulse(1'b1, 1'b0, 2'b01, 1, 1'b0);
        cnt(5);
        check("first_event_state", int'(State), 2);

        // Ack while the count is held at 5, then keep holding
        EventAck = 1'b1; cnt(5);
        EventAck = 1'b0;
        check("ack_to_armed", int'(State), 1);
        check("ack_valid_low", int'(EventValid), 0);
        for (int i = 0; i < 3; i++) cnt(5);
        check("held_tally", int'(MatchTally), 1);
        for (int i = 6; i <= 8; i++) cnt(i);

        // Parallel load 250, compare 0, count through the wrap
        CmpLoad = 1'b1; CmpData = 8'd0; cnt(250);
        CmpLoad = 1'b0;
        for (int i = 251; i <= 255; i++) cnt(i);
        expect_pulse(1'b1, 1'b1, 2'b11, 2, 1'b0);
        cnt(0);
        check("wrap_code", int'(EventCode), 3);

        // Second match with no ack -> overflow, code held
        CmpLoad = 1'b1; CmpData = 8'd3; cnt(1);
        CmpLoad = 1'b0;
        cnt(2);
        expect_pulse(1'b1, 1'b0, 2'b11, 3, 1'b1);
        cnt(3);
        check("ovf_state", int'(State), 2);
        cnt(255);
        // Ack coincides with a new event: no bubble, new code captured
        EventAck = 1'b1;
        expect_pulse(1'b1, 1'b0, 2'b01, 4, 1'b1);
        cnt(3);
        EventAck = 1'b0;
        check("b2b_valid", int'(EventValid), 1);
        check("b2b_code", int'(EventCode), 1);

        // Disarm while pending: event survives until ack, then IDLE
        Arm = 1'b0; cnt(4); cnt(4);
        check("disarm_pending_valid", int'(EventValid), 1);
        EventAck = 1'b1; cnt(4);
        EventAck = 1'b0;
        check("disarm_ack_state", int'(State), 0);
        check("disarm_ack_valid", int'(EventValid), 0);
        cnt(2); cnt(3); cnt(4);
        check("idle_tally", int'(MatchTally), 4);

        // 16 more matches saturate the tally at 15
        Arm = 1'b1; cnt(4);
        EventAck = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cnt(4);
            expect_pulse(1'b1, 1'b0, 2'b01, (4 + k > 15) ? 15 : 4 + k, 1'b1);
            cnt(3);
        end
        EventAck = 1'b0;
        check("sat_tally", int'(MatchTally), 15);
        check("sat_state", int'(State), 2);

        // Reset mid-pending discards everything
        Reset = 1'b1; cnt(3);
        check_all_zero("midreset");
        Reset = 1'b0; Arm = 1'b0;
        cnt(3);
        @(negedge Clock);
        #1;
        check("missing_pulses", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
